idex_fwd_stage: RTL and testbench
=================================

IDEX_FWD_STAGE -- requirements
Module: idex_fwd_stage

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL take parameter RA_W, default 4, giving the register-address width (r0-r15).
REQ-003 The block SHALL have one clock `clk`; reset `reset` is synchronous and active-high.
REQ-004 Ports SHALL be exactly as listed below:
  clk  in  1  clock, rising edge
  reset  in  1  synchronous active-high reset
  id_valid  in  1  decoded instruction present
  id_rs1_addr, id_rs2_addr  in  RA_W  source register numbers
  id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
  id_imm  in  DATA_WIDTH  extended immediate
  id_use_imm  in  1  B operand = immediate
  id_aluctrl  in  4  ALU op code (0000 = NOP)
  id_rd_addr  in  RA_W  destination register
  id_rd_we, id_mem_rd, id_mem_wr  in  1  writeback, load, store controls
  stall_in  in  1  external hold from downstream
  flush  in  1  branch-taken squash
  mem_fwd_we / mem_fwd_addr / mem_fwd_data  in  1/RA_W/DATA_WIDTH  EX/MEM result
  wb_fwd_we / wb_fwd_addr / wb_fwd_data  in  1/RA_W/DATA_WIDTH  MEM/WB result
  ex_A, ex_B  out  DATA_WIDTH  ALU operands (forwarded)
  ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
  ex_aluctrl  out  4  ALU op code
  ex_valid, ex_rd_we, ex_mem_rd, ex_mem_wr  out  1  registered controls
  ex_rd_addr  out  RA_W  registered destination
  load_use_stall  out  1  upstream must hold IF/ID this cycle
  bubble_cnt  out  16  saturating count of inserted bubbles

Function
REQ-005 The block SHALL register all id_* fields into EX-stage registers on each rising clk edge, subject to REQ-006 through REQ-009.
REQ-006 load_use_stall SHALL be combinational: ex_valid & ex_mem_rd & id_valid & (ex_rd_addr==id_rs1_addr | (ex_rd_addr==id_rs2_addr & (~id_use_imm | id_mem_wr))).
REQ-007 Priority per edge SHALL be flush > stall_in > load_use_stall > normal load.
REQ-008 On flush or load_use_stall the block SHALL load a bubble: ex_valid=0, ex_aluctrl=0000, ex_rd_we=0, ex_mem_rd=0, ex_mem_wr=0; data registers are don't-care.
REQ-009 With stall_in asserted and flush deasserted, the block SHALL hold every EX register unchanged.
REQ-010 If id_valid=0 during a normal load, the block SHALL load a bubble.
REQ-011 Operand forwarding SHALL be combinational from the registered rs addresses and data: MEM match (mem_fwd_we & mem_fwd_addr==rsN) wins, then WB match, else registered register-file data.
REQ-012 ex_A SHALL equal forwarded rs1; ex_B SHALL equal the registered immediate when use_imm=1, otherwise forwarded rs2.
REQ-013 ex_store_data SHALL equal forwarded rs2 regardless of use_imm.
REQ-014 When ex_valid=0, ex_A, ex_B and ex_store_data SHALL be 0, so that a NOP ALU produces Z=0.
REQ-015 bubble_cnt SHALL increment by 1 on each edge where a bubble is loaded because of flush or load_use_stall, and SHALL saturate at 16'hFFFF.
REQ-016 A stall_in edge SHALL NOT increment bubble_cnt.
REQ-017 Latency SHALL be one cycle from an accepted id_* instruction to the ex_* outputs.
REQ-018 Forwarding SHALL add no cycles.

Reset
REQ-019 While reset=1 at a clk edge, every EX register SHALL clear to 0: ex_valid=0, ex_aluctrl=0000, all controls 0, bubble_cnt=0.
REQ-020 Reset SHALL override flush and stall, and SHALL discard any in-flight instruction.
REQ-021 load_use_stall SHALL be 0 in the first cycle after reset.

Verification
REQ-022 ADD r3=r1+r2, rs1_data=5, rs2_data=7, no forwarding -> next cycle ex_A=5, ex_B=7, ex_aluctrl=0001, ex_valid=1.
REQ-023 Both forwarding paths active on rs1: mem_fwd r1=0x10 and wb_fwd r1=0x20 -> ex_A=0x10; with mem_fwd_we dropped -> ex_A=0x20.
REQ-024 Load r4 in EX, ID uses r4 as rs1 -> load_use_stall=1, next cycle ex_valid=0, ex_aluctrl=0000, bubble_cnt=1.
REQ-025 flush and stall_in both asserted with a valid ID instruction -> bubble loaded, bubble_cnt increments; stall_in alone for 3 cycles -> EX registers unchanged, bubble_cnt unchanged.
REQ-026 Force 65537 consecutive flushes -> bubble_cnt=0xFFFF; then assert reset mid-stream -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/idex_fwd_stage.sv
// ID/EX pipeline register with operand forwarding, load-use hazard
// detection and a saturating bubble counter.
module idex_fwd_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int RA_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  id_valid,
    input  logic [RA_W-1:0]       id_rs1_addr,
    input  logic [RA_W-1:0]       id_rs2_addr,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_use_imm,
    input  logic [3:0]            id_aluctrl,
    input  logic [RA_W-1:0]       id_rd_addr,
    input  logic                  id_rd_we,
    input  logic                  id_mem_rd,
    input  logic                  id_mem_wr,

    input  logic                  stall_in,
    input  logic                  flush,

    input  logic                  mem_fwd_we,
    input  logic [RA_W-1:0]       mem_fwd_addr,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic                  wb_fwd_we,
    input  logic [RA_W-1:0]       wb_fwd_addr,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data,

    output logic [DATA_WIDTH-1:0] ex_A,
    output logic [DATA_WIDTH-1:0] ex_B,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [3:0]            ex_aluctrl,
    output logic                  ex_valid,
    output logic                  ex_rd_we,
    output logic                  ex_mem_rd,
    output logic                  ex_mem_wr,
    output logic [RA_W-1:0]       ex_rd_addr,
    output logic                  load_use_stall,
    output logic [15:0]           bubble_cnt
);

    // What the EX registers do on the coming edge (reset aside).
    typedef enum logic [1:0] {
        ACT_LOAD,        // capture the ID instruction
        ACT_HOLD,        // keep everything as is
        ACT_BUBBLE,      // empty slot, not counted (no instruction in ID)
        ACT_BUBBLE_CNT   // inserted bubble: flush or load-use
    } ex_act_t;

    ex_act_t               act;

    logic [RA_W-1:0]       rs1_addr_q;
    logic [RA_W-1:0]       rs2_addr_q;
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  use_imm_q;

    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    // Load in EX whose destination is read by the instruction in ID.
    // rs2 only matters when it is actually consumed: as ALU B or as store data.
    always_comb begin
        load_use_stall = 1'b0;
        if (ex_valid && ex_mem_rd && id_valid) begin
            if (ex_rd_addr == id_rs1_addr) begin
                load_use_stall = 1'b1;
            end else if ((ex_rd_addr == id_rs2_addr) && (!id_use_imm || id_mem_wr)) begin
                load_use_stall = 1'b1;
            end
        end
    end

    // Edge action priority: flush, then downstream stall, then load-use, then load.
    always_comb begin
        act = ACT_LOAD;
        if (flush) begin
            act = ACT_BUBBLE_CNT;
        end else if (stall_in) begin
            act = ACT_HOLD;
        end else if (load_use_stall) begin
            act = ACT_BUBBLE_CNT;
        end else if (!id_valid) begin
            act = ACT_BUBBLE;
        end
    end

    // EX control registers; bubbles clear every control bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_aluctrl <= '0;
            ex_rd_we   <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_rd_addr <= '0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    ex_valid   <= 1'b1;
                    ex_aluctrl <= id_aluctrl;
                    ex_rd_we   <= id_rd_we;
                    ex_mem_rd  <= id_mem_rd;
                    ex_mem_wr  <= id_mem_wr;
                    ex_rd_addr <= id_rd_addr;
                end
                ACT_HOLD: begin
                    ex_valid   <= ex_valid;
                    ex_aluctrl <= ex_aluctrl;
                    ex_rd_we   <= ex_rd_we;
                    ex_mem_rd  <= ex_mem_rd;
                    ex_mem_wr  <= ex_mem_wr;
                    ex_rd_addr <= ex_rd_addr;
                end
                default: begin
                    ex_valid   <= 1'b0;
                    ex_aluctrl <= '0;
                    ex_rd_we   <= 1'b0;
                    ex_mem_rd  <= 1'b0;
                    ex_mem_wr  <= 1'b0;
                    ex_rd_addr <= '0;
                end
            endcase
        end
    end

    // EX operand registers; contents of a bubble are masked at the outputs,
    // so they are simply cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    rs1_addr_q <= id_rs1_addr;
                    rs2_addr_q <= id_rs2_addr;
                    rs1_data_q <= id_rs1_data;
                    rs2_data_q <= id_rs2_data;
                    imm_q      <= id_imm;
                    use_imm_q  <= id_use_imm;
                end
                ACT_HOLD: begin
                    rs1_addr_q <= rs1_addr_q;
                    rs2_addr_q <= rs2_addr_q;
                    rs1_data_q <= rs1_data_q;
                    rs2_data_q <= rs2_data_q;
                    imm_q      <= imm_q;
                    use_imm_q  <= use_imm_q;
                end
                default: begin
                    rs1_addr_q <= '0;
                    rs2_addr_q <= '0;
                    rs1_data_q <= '0;
                    rs2_data_q <= '0;
                    imm_q      <= '0;
                    use_imm_q  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of bubbles inserted by flush or load-use.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if ((act == ACT_BUBBLE_CNT) && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB, else register file.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (mem_fwd_we && (mem_fwd_addr == rs1_addr_q)) begin
            rs1_fwd = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == rs1_addr_q)) begin
            rs1_fwd = wb_fwd_data;
        end

        rs2_fwd = rs2_data_q;
        if (mem_fwd_we && (mem_fwd_addr == rs2_addr_q)) begin
            rs2_fwd = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == rs2_addr_q)) begin
            rs2_fwd = wb_fwd_data;
        end
    end

    // Operand outputs, forced to zero for an empty slot so a NOP ALU yields 0.
    always_comb begin
        ex_A          = '0;
        ex_B          = '0;
        ex_store_data = '0;
        if (ex_valid) begin
            ex_A          = rs1_fwd;
            ex_B          = use_imm_q ? imm_q : rs2_fwd;
            ex_store_data = rs2_fwd;
        end
    end

endmodule

// File: tb/tb_idex_fwd_stage.sv
// Self-checking bench for idex_fwd_stage: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_idex_fwd_stage;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic          id_use_imm, id_rd_we, id_mem_rd, id_mem_wr;
    logic [3:0]    id_aluctrl;
    logic          stall_in, flush;
    logic          mem_fwd_we, wb_fwd_we;
    logic [AW-1:0] mem_fwd_addr, wb_fwd_addr;
    logic [DW-1:0] mem_fwd_data, wb_fwd_data;
    logic [DW-1:0] ex_A, ex_B, ex_store_data;
    logic [3:0]    ex_aluctrl;
    logic          ex_valid, ex_rd_we, ex_mem_rd, ex_mem_wr;
    logic [AW-1:0] ex_rd_addr;
    logic          load_use_stall;
    logic [15:0]   bubble_cnt;

    int checks = 0;
    int errors = 0;

    idex_fwd_stage #(.DATA_WIDTH(DW), .RA_W(AW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_aluctrl(id_aluctrl), .id_rd_addr(id_rd_addr),
        .id_rd_we(id_rd_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .stall_in(stall_in), .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .ex_A(ex_A), .ex_B(ex_B), .ex_store_data(ex_store_data), .ex_aluctrl(ex_aluctrl),
        .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_rd_addr(ex_rd_addr), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction sitting in EX, as a transaction record.
    typedef struct {
        bit            valid;
        bit [3:0]      op;
        bit            rd_we, mem_rd, mem_wr, use_imm;
        bit [AW-1:0]   rd, rs1, rs2;
        bit [DW-1:0]   d1, d2, imm;
    } instr_t;

    instr_t m_ex;
    int     m_bubbles;

    function automatic bit hazard();
        if (!(m_ex.valid && m_ex.mem_rd && id_valid)) return 0;
        if (m_ex.rd == id_rs1_addr) return 1;
        return (m_ex.rd == id_rs2_addr) && (!id_use_imm || id_mem_wr);
    endfunction

    function automatic bit [DW-1:0] operand(input bit [AW-1:0] a, input bit [DW-1:0] rf);
        if (mem_fwd_we && mem_fwd_addr == a) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_addr == a) return wb_fwd_data;
        return rf;
    endfunction

    function automatic void add_bubble();
        m_ex.valid = 0;
        if (m_bubbles < 65535) m_bubbles++;
    endfunction

    // Apply one clock edge to the model, using the inputs present at the edge.
    function automatic void model_edge();
        instr_t empty;
        empty = '{default: 0};
        if (reset) begin
            m_ex = empty;
            m_bubbles = 0;
        end else if (flush) begin
            add_bubble();
        end else if (stall_in) begin
            // instruction stays in EX
        end else if (hazard()) begin
            add_bubble();
        end else if (!id_valid) begin
            m_ex.valid = 0;
        end else begin
            m_ex = '{valid: 1, op: id_aluctrl, rd_we: id_rd_we, mem_rd: id_mem_rd,
                     mem_wr: id_mem_wr, use_imm: id_use_imm, rd: id_rd_addr,
                     rs1: id_rs1_addr, rs2: id_rs2_addr, d1: id_rs1_data,
                     d2: id_rs2_data, imm: id_imm};
        end
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        bit [DW-1:0] a, s, b;
        a = m_ex.valid ? operand(m_ex.rs1, m_ex.d1) : '0;
        s = m_ex.valid ? operand(m_ex.rs2, m_ex.d2) : '0;
        b = m_ex.valid ? (m_ex.use_imm ? m_ex.imm : s) : '0;
        check("ex_valid", ex_valid, m_ex.valid);
        check("ex_aluctrl", ex_aluctrl, m_ex.valid ? m_ex.op : 4'd0);
        check("ex_rd_we", ex_rd_we, m_ex.valid & m_ex.rd_we);
        check("ex_mem_rd", ex_mem_rd, m_ex.valid & m_ex.mem_rd);
        check("ex_mem_wr", ex_mem_wr, m_ex.valid & m_ex.mem_wr);
        if (m_ex.valid) check("ex_rd_addr", ex_rd_addr, m_ex.rd);
        check("ex_A", ex_A, a);
        check("ex_B", ex_B, b);
        check("ex_store_data", ex_store_data, s);
        check("load_use_stall", load_use_stall, hazard());
        check("bubble_cnt", bubble_cnt, m_bubbles);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
        id_aluctrl = 0; id_rd_we = 0; id_mem_rd = 0; id_mem_wr = 0;
        stall_in = 0; flush = 0;
        mem_fwd_we = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
        wb_fwd_we = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
    endtask

    task automatic set_id(input bit [AW-1:0] rs1, input bit [AW-1:0] rs2, input bit [DW-1:0] d1,
                          input bit [DW-1:0] d2, input bit [3:0] op, input bit [AW-1:0] rd,
                          input bit ld, input bit st, input bit ui, input bit [DW-1:0] imm);
        id_valid = 1; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1;
        id_rs2_data = d2; id_aluctrl = op; id_rd_addr = rd; id_mem_rd = ld;
        id_mem_wr = st; id_rd_we = !st; id_use_imm = ui; id_imm = imm;
    endtask

    initial begin
        m_ex = '{default: 0};
        m_bubbles = 0;
        idle_inputs();
        reset = 1;

        // Reset state
        tick(); tick();
        reset = 0;
        set_id(4'd0, 4'd0, 32'h1, 32'h2, 4'd1, 4'd5, 0, 0, 0, 0);
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_no_load_use", load_use_stall, 0);
        check_model();

        // ADD r3 = r1 + r2 without forwarding
        set_id(4'd1, 4'd2, 32'd5, 32'd7, 4'b0001, 4'd3, 0, 0, 0, 0);
        tick();
        idle_inputs();
        #1;
        check("add_A", ex_A, 32'd5);
        check("add_B", ex_B, 32'd7);
        check("add_op", ex_aluctrl, 4'b0001);
        check("add_valid", ex_valid, 1);
        check_model();

        // Both forwarding sources match rs1: EX/MEM wins, then MEM/WB
        set_id(4'd1, 4'd2, 32'd0, 32'd9, 4'b0010, 4'd6, 0, 0, 0, 0);
        tick();
        idle_inputs();
        mem_fwd_we = 1; mem_fwd_addr = 4'd1; mem_fwd_data = 32'h10;
        wb_fwd_we = 1; wb_fwd_addr = 4'd1; wb_fwd_data = 32'h20;
        #1;
        check("fwd_mem_A", ex_A, 32'h10);
        check_model();
        mem_fwd_we = 0;
        #1;
        check("fwd_wb_A", ex_A, 32'h20);
        check_model();

        // Load r4 followed by a consumer of r4
        idle_inputs();
        set_id(4'd7, 4'd8, 32'h100, 32'h0, 4'b0001, 4'd4, 1, 0, 1, 32'h4);
        tick();
        set_id(4'd4, 4'd9, 32'h1, 32'h2, 4'b0011, 4'd10, 0, 0, 0, 0);
        #1;
        check("lu_stall", load_use_stall, 1);
        check_model();
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_op", ex_aluctrl, 4'd0);
        check("lu_bubble_cnt", bubble_cnt, 16'd1);
        check_model();

        // flush beats stall_in
        flush = 1; stall_in = 1;
        tick();
        flush = 0; stall_in = 0;
        check("fs_valid", ex_valid, 0);
        check("fs_cnt", bubble_cnt, 16'd2);
        check_model();

        // stall_in alone for three cycles holds EX
        set_id(4'd11, 4'd12, 32'hAB, 32'hCD, 4'b0101, 4'd13, 0, 0, 0, 0);
        tick();
        idle_inputs();
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_A", ex_A, 32'hAB);
            check("hold_op", ex_aluctrl, 4'b0101);
            check("hold_cnt", bubble_cnt, 16'd2);
            check_model();
        end
        stall_in = 0;

        // Randomized traffic with a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs1_addr  = AW'($urandom_range(0, 3));
            id_rs2_addr  = AW'($urandom_range(0, 3));
            id_rd_addr   = AW'($urandom_range(0, 3));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_use_imm   = $urandom_range(0, 1);
            id_aluctrl   = 4'($urandom);
            id_rd_we     = $urandom_range(0, 1);
            id_mem_rd    = ($urandom_range(0, 2) == 0);
            id_mem_wr    = ($urandom_range(0, 3) == 0);
            stall_in     = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 99) == 0);
            mem_fwd_we   = $urandom_range(0, 1);
            mem_fwd_addr = AW'($urandom_range(0, 3));
            mem_fwd_data = $urandom;
            wb_fwd_we    = $urandom_range(0, 1);
            wb_fwd_addr  = AW'($urandom_range(0, 3));
            wb_fwd_data  = $urandom;
            #1;
            check_model();
            tick();
        end
        reset = 0;
        idle_inputs();
        #1;
        check_model();

        // Counter saturation and reset in the middle of a flush stream
        flush = 1;
        set_id(4'd1, 4'd2, 32'h5, 32'h6, 4'b0001, 4'd3, 0, 0, 0, 0);
        for (int i = 0; i < 65537; i++) tick();
        check("sat_cnt", bubble_cnt, 16'hFFFF);
        check_model();
        reset = 1;
        tick();
        reset = 0;
        flush = 0;
        idle_inputs();
        #1;
        check("rst2_cnt", bubble_cnt, 0);
        check("rst2_valid", ex_valid, 0);
        check("rst2_op", ex_aluctrl, 0);
        check("rst2_A", ex_A, 0);
        check("rst2_B", ex_B, 0);
        check("rst2_st", ex_store_data, 0);
        check("rst2_ctl", {ex_rd_we, ex_mem_rd, ex_mem_wr}, 0);
        check("rst2_rd", ex_rd_addr, 0);
        check("rst2_lus", load_use_stall, 0);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
